// File: rtl/periph_pkg.sv
// Shared definitions for the core-data bridge and its peripheral register page:
// register offsets, bridge FSM states and the byte-enable merge helper.
package periph_pkg;

    localparam logic [31:0] PERIPH_PAGE_DEFAULT = 32'h3FF;

    localparam logic [11:0] OFF_DISP0   = 12'h000;
    localparam logic [11:0] OFF_DISP1   = 12'h004;
    localparam logic [11:0] OFF_DISP2   = 12'h008;
    localparam logic [11:0] OFF_DISP3   = 12'h00C;
    localparam logic [11:0] OFF_CYCLE   = 12'h010;
    localparam logic [11:0] OFF_SCRATCH = 12'h014;
    localparam logic [11:0] OFF_ERRCNT  = 12'h018;

    localparam logic [7:0] ERRCNT_MAX = 8'hFF;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_RAM_WAIT = 2'd1,
        ST_PER_RESP = 2'd2
    } bridge_state_e;

    function automatic logic [31:0] merge_be(input logic [31:0] old_v,
                                             input logic [31:0] new_v,
                                             input logic [3:0]  be);
        logic [31:0] result;
        for (int i = 0; i < 4; i++) begin
            result[8*i +: 8] = be[i] ? new_v[8*i +: 8] : old_v[8*i +: 8];
        end
        return result;
    endfunction

endpackage

// File: rtl/periph_regs.sv
// Peripheral register page: four display registers, free-running cycle counter,
// scratch register and a saturating count of unmapped accesses.
module periph_regs
    import periph_pkg::*;
(
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        acc_i,
    input  logic        we_i,
    input  logic [11:0] off_i,
    input  logic [3:0]  be_i,
    input  logic [31:0] wdata_i,
    output logic [31:0] rdata_o,
    output logic        err_o,
    output logic [31:0] disp0_o,
    output logic [31:0] disp1_o,
    output logic [31:0] disp2_o,
    output logic [31:0] disp3_o
);

    logic [31:0] disp_q [4];
    logic [31:0] disp_d [4];
    logic [31:0] cycle_q, cycle_d;
    logic [31:0] scratch_q, scratch_d;
    logic [7:0]  errcnt_q, errcnt_d;
    logic        wr;

    // Read path sees only the current register state, never a same-cycle write.
    always_comb begin
        rdata_o = '0;
        err_o   = 1'b0;
        case (off_i)
            OFF_DISP0:   rdata_o = disp_q[0];
            OFF_DISP1:   rdata_o = disp_q[1];
            OFF_DISP2:   rdata_o = disp_q[2];
            OFF_DISP3:   rdata_o = disp_q[3];
            OFF_CYCLE:   rdata_o = cycle_q;
            OFF_SCRATCH: rdata_o = scratch_q;
            OFF_ERRCNT:  rdata_o = {24'b0, errcnt_q};
            default:     err_o   = 1'b1;
        endcase
    end

    assign wr = acc_i && we_i && !err_o;

    always_comb begin
        disp_d    = disp_q;
        cycle_d   = cycle_q + 32'd1;
        scratch_d = scratch_q;
        errcnt_d  = errcnt_q;
        if (acc_i && err_o && errcnt_q != ERRCNT_MAX) begin
            errcnt_d = errcnt_q + 8'd1;
        end
        // Clears are applied last so they win over any increment.
        if (wr) begin
            case (off_i)
                OFF_DISP0:   disp_d[0] = merge_be(disp_q[0], wdata_i, be_i);
                OFF_DISP1:   disp_d[1] = merge_be(disp_q[1], wdata_i, be_i);
                OFF_DISP2:   disp_d[2] = merge_be(disp_q[2], wdata_i, be_i);
                OFF_DISP3:   disp_d[3] = merge_be(disp_q[3], wdata_i, be_i);
                OFF_CYCLE:   cycle_d   = '0;
                OFF_SCRATCH: scratch_d = merge_be(scratch_q, wdata_i, be_i);
                OFF_ERRCNT:  errcnt_d  = '0;
                default:     ;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            disp_q    <= '{default: '0};
            cycle_q   <= '0;
            scratch_q <= '0;
            errcnt_q  <= '0;
        end else begin
            disp_q    <= disp_d;
            cycle_q   <= cycle_d;
            scratch_q <= scratch_d;
            errcnt_q  <= errcnt_d;
        end
    end

    assign disp0_o = disp_q[0];
    assign disp1_o = disp_q[1];
    assign disp2_o = disp_q[2];
    assign disp3_o = disp_q[3];

endmodule

// File: rtl/data_periph_bridge.sv
// Splits core data accesses between an external RAM port and the local peripheral
// page; one transaction outstanding, peripheral responses one cycle after grant.
module data_periph_bridge
    import periph_pkg::*;
#(
    parameter int          ADDR_WIDTH  = 22,
    parameter logic [31:0] PERIPH_PAGE = PERIPH_PAGE_DEFAULT
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  data_req_i,
    input  logic                  data_we_i,
    input  logic [ADDR_WIDTH-1:0] data_addr_i,
    input  logic [3:0]            data_be_i,
    input  logic [31:0]           data_wdata_i,
    output logic                  data_gnt_o,
    output logic                  data_rvalid_o,
    output logic                  data_err_o,
    output logic [31:0]           data_rdata_o,
    output logic                  ram_req_o,
    output logic                  ram_we_o,
    output logic [ADDR_WIDTH-1:0] ram_addr_o,
    output logic [3:0]            ram_be_o,
    output logic [31:0]           ram_wdata_o,
    input  logic                  ram_gnt_i,
    input  logic                  ram_rvalid_i,
    input  logic [31:0]           ram_rdata_i,
    output logic [31:0]           disp0_o,
    output logic [31:0]           disp1_o,
    output logic [31:0]           disp2_o,
    output logic [31:0]           disp3_o
);

    bridge_state_e state_q;
    logic [31:0]   resp_rdata_q;
    logic          resp_err_q;
    logic          is_per, can_accept, per_acc, ram_fwd;
    logic [31:0]   reg_rdata;
    logic          reg_err;

    assign is_per = (data_addr_i[ADDR_WIDTH-1:12] == PERIPH_PAGE[ADDR_WIDTH-13:0]);

    // A new request is accepted when nothing is outstanding, or in the very
    // cycle the outstanding RAM response returns.
    assign can_accept = !rst_i && (state_q != ST_RAM_WAIT || ram_rvalid_i);
    assign per_acc    = can_accept && data_req_i && is_per;
    assign ram_fwd    = can_accept && data_req_i && !is_per;

    assign ram_req_o   = ram_fwd;
    assign ram_we_o    = data_we_i;
    assign ram_addr_o  = data_addr_i;
    assign ram_be_o    = data_be_i;
    assign ram_wdata_o = data_wdata_i;
    assign data_gnt_o  = per_acc || (ram_fwd && ram_gnt_i);

    periph_regs u_regs (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .acc_i   (per_acc),
        .we_i    (data_we_i),
        .off_i   (data_addr_i[11:0]),
        .be_i    (data_be_i),
        .wdata_i (data_wdata_i),
        .rdata_o (reg_rdata),
        .err_o   (reg_err),
        .disp0_o (disp0_o),
        .disp1_o (disp1_o),
        .disp2_o (disp2_o),
        .disp3_o (disp3_o)
    );

    always_comb begin
        data_rvalid_o = 1'b0;
        data_rdata_o  = '0;
        data_err_o    = 1'b0;
        if (!rst_i) begin
            case (state_q)
                ST_RAM_WAIT: begin
                    data_rvalid_o = ram_rvalid_i;
                    data_rdata_o  = ram_rdata_i;
                end
                ST_PER_RESP: begin
                    data_rvalid_o = 1'b1;
                    data_rdata_o  = resp_rdata_q;
                    data_err_o    = resp_err_q;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q      <= ST_IDLE;
            resp_rdata_q <= '0;
            resp_err_q   <= 1'b0;
        end else if (per_acc) begin
            state_q      <= ST_PER_RESP;
            resp_rdata_q <= data_we_i ? 32'd0 : reg_rdata;
            resp_err_q   <= reg_err;
        end else if (ram_fwd && ram_gnt_i) begin
            state_q <= ST_RAM_WAIT;
        end else if (can_accept) begin
            state_q <= ST_IDLE;
        end
    end

endmodule

// File: tb/tb_data_periph_bridge.sv
// Directed bench for data_periph_bridge; the peripheral page is placed at 0xFFC
// in a 24-bit address space so 0xFFCxxx addresses hit the register page.
module tb_data_periph_bridge;
  import periph_pkg::*;

  localparam int AW = 24;

  logic          clk = 1'b0;
  logic          rst;
  logic          data_req, data_we;
  logic [AW-1:0] data_addr;
  logic [3:0]    data_be;
  logic [31:0]   data_wdata;
  logic          data_gnt_o, data_rvalid_o, data_err_o;
  logic [31:0]   data_rdata_o;
  logic          ram_req_o, ram_we_o;
  logic [AW-1:0] ram_addr_o;
  logic [3:0]    ram_be_o;
  logic [31:0]   ram_wdata_o;
  logic          ram_gnt, ram_rvalid;
  logic [31:0]   ram_rdata;
  logic [31:0]   disp0_o, disp1_o, disp2_o, disp3_o;

  int checks = 0;
  int passed = 0;

  always #5 clk = ~clk;

  data_periph_bridge #(.ADDR_WIDTH(AW), .PERIPH_PAGE(32'hFFC)) dut (
    .clk_i(clk), .rst_i(rst),
    .data_req_i(data_req), .data_we_i(data_we), .data_addr_i(data_addr),
    .data_be_i(data_be), .data_wdata_i(data_wdata),
    .data_gnt_o(data_gnt_o), .data_rvalid_o(data_rvalid_o),
    .data_err_o(data_err_o), .data_rdata_o(data_rdata_o),
    .ram_req_o(ram_req_o), .ram_we_o(ram_we_o), .ram_addr_o(ram_addr_o),
    .ram_be_o(ram_be_o), .ram_wdata_o(ram_wdata_o),
    .ram_gnt_i(ram_gnt), .ram_rvalid_i(ram_rvalid), .ram_rdata_i(ram_rdata),
    .disp0_o(disp0_o), .disp1_o(disp1_o), .disp2_o(disp2_o), .disp3_o(disp3_o)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
  endtask

  // One peripheral access: request for one cycle, then collect the response.
  task automatic per_access(input logic we, input logic [11:0] off, input logic [3:0] be,
                            input logic [31:0] wd, output logic [31:0] rd, output logic err);
    @(posedge clk); #1;
    data_req = 1'b1; data_we = we; data_addr = {12'hFFC, off}; data_be = be; data_wdata = wd;
    @(negedge clk);
    check("per_gnt", {31'b0, data_gnt_o}, 32'd1);
    @(posedge clk); #1;
    data_req = 1'b0; data_we = 1'b0;
    @(negedge clk);
    check("per_rvalid", {31'b0, data_rvalid_o}, 32'd1);
    rd  = data_rdata_o;
    err = data_err_o;
  endtask

  initial begin
    logic [31:0] rd, r1, r2;
    logic        err;

    rst = 1'b1; ram_gnt = 1'b0; ram_rvalid = 1'b0; ram_rdata = '0;
    data_req = 1'b1; data_we = 1'b0; data_addr = 24'h000200; data_be = 4'hF; data_wdata = '0;
    @(negedge clk);
    check("rst_ram_req", {31'b0, ram_req_o}, 32'd0);
    check("rst_gnt", {31'b0, data_gnt_o}, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0; data_req = 1'b0;
    @(negedge clk);
    check("rst_rvalid", {31'b0, data_rvalid_o}, 32'd0);
    check("rst_err", {31'b0, data_err_o}, 32'd0);
    check("rst_rdata", data_rdata_o, 32'd0);
    check("rst_disp0", disp0_o, 32'd0);
    check("rst_disp3", disp3_o, 32'd0);

    // Partial-byte write to DISP0.
    per_access(1'b1, OFF_DISP0, 4'b0101, 32'h12345678, rd, err);
    check("wr_rdata", rd, 32'd0);
    check("wr_err", {31'b0, err}, 32'd0);
    check("disp0_be", disp0_o, 32'h00340078);
    @(negedge clk);
    check("rvalid_one_cycle", {31'b0, data_rvalid_o}, 32'd0);
    per_access(1'b1, OFF_DISP3, 4'hF, 32'hA5A50001, rd, err);
    check("disp3_full", disp3_o, 32'hA5A50001);
    per_access(1'b0, OFF_DISP0, 4'hF, 32'd0, rd, err);
    check("rd_disp0", rd, 32'h00340078);

    // SCRATCH byte-lane write.
    per_access(1'b1, OFF_SCRATCH, 4'hF, 32'hFFFFFFFF, rd, err);
    per_access(1'b1, OFF_SCRATCH, 4'b1000, 32'h00000000, rd, err);
    per_access(1'b0, OFF_SCRATCH, 4'hF, 32'd0, rd, err);
    check("scratch_be", rd, 32'h00FFFFFF);

    // Back-to-back CYCLE reads on consecutive grants.
    @(posedge clk); #1;
    data_req = 1'b1; data_we = 1'b0; data_addr = 24'hFFC010;
    @(negedge clk);
    check("cyc_gnt0", {31'b0, data_gnt_o}, 32'd1);
    @(posedge clk); #1;
    @(negedge clk);
    check("cyc_gnt1", {31'b0, data_gnt_o}, 32'd1);
    check("cyc_rvalid0", {31'b0, data_rvalid_o}, 32'd1);
    r1 = data_rdata_o;
    @(posedge clk); #1;
    data_req = 1'b0;
    @(negedge clk);
    check("cyc_rvalid1", {31'b0, data_rvalid_o}, 32'd1);
    r2 = data_rdata_o;
    check("cyc_delta", r2 - r1, 32'd1);
    per_access(1'b1, OFF_CYCLE, 4'hF, 32'hDEADBEEF, rd, err);
    per_access(1'b0, OFF_CYCLE, 4'hF, 32'd0, rd, err);
    check("cyc_after_clear", rd, 32'd1);

    // RAM read: grant withheld two cycles, response the cycle after grant,
    // peripheral request waiting behind it.
    @(posedge clk); #1;
    data_req = 1'b1; data_we = 1'b0; data_addr = 24'h000100; data_be = 4'hF;
    @(negedge clk);
    check("ram_req_fwd", {31'b0, ram_req_o}, 32'd1);
    check("ram_addr_fwd", {8'b0, ram_addr_o}, 32'h00000100);
    check("ram_we_fwd", {31'b0, ram_we_o}, 32'd0);
    check("ram_nogrant0", {31'b0, data_gnt_o}, 32'd0);
    @(posedge clk); #1;
    @(negedge clk);
    check("ram_nogrant1", {31'b0, data_gnt_o}, 32'd0);
    @(posedge clk); #1;
    ram_gnt = 1'b1;
    @(negedge clk);
    check("ram_grant", {31'b0, data_gnt_o}, 32'd1);
    @(posedge clk); #1;
    ram_gnt = 1'b0; ram_rvalid = 1'b1; ram_rdata = 32'hCAFEF00D;
    data_addr = 24'hFFC000;
    @(negedge clk);
    check("ram_rvalid", {31'b0, data_rvalid_o}, 32'd1);
    check("ram_rdata", data_rdata_o, 32'hCAFEF00D);
    check("ram_err", {31'b0, data_err_o}, 32'd0);
    check("per_gnt_in_rvalid", {31'b0, data_gnt_o}, 32'd1);
    check("per_not_to_ram", {31'b0, ram_req_o}, 32'd0);
    @(posedge clk); #1;
    ram_rvalid = 1'b0; data_req = 1'b0;
    @(negedge clk);
    check("b2b_per_rvalid", {31'b0, data_rvalid_o}, 32'd1);
    check("b2b_per_rdata", data_rdata_o, 32'h00340078);

    // Unmapped offset: 300 accesses, half writes that must change nothing.
    for (int i = 0; i < 300; i++) begin
      per_access(i[0], 12'h020, 4'hF, 32'hFFFFFFFF, rd, err);
      check("unmap_err", {31'b0, err}, 32'd1);
      check("unmap_rdata", rd, 32'd0);
    end
    check("unmap_disp0_kept", disp0_o, 32'h00340078);
    per_access(1'b0, OFF_SCRATCH, 4'hF, 32'd0, rd, err);
    check("unmap_scratch_kept", rd, 32'h00FFFFFF);
    per_access(1'b0, OFF_ERRCNT, 4'hF, 32'd0, rd, err);
    check("errcnt_sat", rd, 32'd255);
    per_access(1'b1, OFF_ERRCNT, 4'h0, 32'd0, rd, err);
    per_access(1'b0, OFF_ERRCNT, 4'hF, 32'd0, rd, err);
    check("errcnt_clear", rd, 32'd0);

    // Reset while a RAM write is outstanding; a late rvalid must be dropped.
    @(posedge clk); #1;
    data_req = 1'b1; data_we = 1'b1; data_addr = 24'h000040; data_be = 4'b0011;
    data_wdata = 32'h0BADF00D; ram_gnt = 1'b1;
    @(negedge clk);
    check("ramw_we", {31'b0, ram_we_o}, 32'd1);
    check("ramw_be", {28'b0, ram_be_o}, 32'h3);
    check("ramw_wdata", ram_wdata_o, 32'h0BADF00D);
    @(posedge clk); #1;
    ram_gnt = 1'b0; data_we = 1'b0; data_addr = 24'hFFC014;
    @(negedge clk);
    check("wait_no_gnt", {31'b0, data_gnt_o}, 32'd0);
    check("wait_no_fwd", {31'b0, ram_req_o}, 32'd0);
    check("wait_no_rvalid", {31'b0, data_rvalid_o}, 32'd0);
    @(posedge clk); #1;
    rst = 1'b1; data_req = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0; ram_rvalid = 1'b1; ram_rdata = 32'h5555AAAA;
    @(negedge clk);
    check("late_rvalid", {31'b0, data_rvalid_o}, 32'd0);
    check("late_rdata", data_rdata_o, 32'd0);
    check("late_err", {31'b0, data_err_o}, 32'd0);
    check("late_gnt", {31'b0, data_gnt_o}, 32'd0);
    check("late_ram_req", {31'b0, ram_req_o}, 32'd0);
    check("late_disp0", disp0_o, 32'd0);
    check("late_disp3", disp3_o, 32'd0);
    @(posedge clk); #1;
    ram_rvalid = 1'b0;
    per_access(1'b0, OFF_SCRATCH, 4'hF, 32'd0, rd, err);
    check("post_rst_scratch", rd, 32'd0);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
